// File: rtl/tick_scheduler_pkg.sv
// Shared types and defaults for the tick scheduler: run-state encoding, channel ids, reset periods.
// No logic; imported by tick_channel and tick_scheduler.
// Backpressure: n/a.
package tick_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [1:0] CH_PIX  = 2'd0;
    localparam logic [1:0] CH_SCAN = 2'd1;
    localparam logic [1:0] CH_PHYS = 2'd2;

    localparam int DEF_CNT_W    = 20;
    localparam int DEF_PIX_DIV  = 4;
    localparam int DEF_SCAN_DIV = 65536;
    localparam int DEF_PHYS_DIV = 524288;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: down-counter with shadowed period, pending-update flag and reload logic.
// Latency: tick is high in the cycle the counter reads 0; a shadow loaded at edge N is pending from N+1.
// Backpressure: o_pending stays high until the shadow is applied; the parent gates new loads on it.
module tick_channel
    import tick_scheduler_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RST_DIV = DEF_PIX_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_freeze,
    input  logic             i_hold_reload,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_div,
    output logic             o_tick,
    output logic             o_pending
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_DIV_W = CNT_W'(RST_DIV);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;

    logic [CNT_W-1:0] w_shadow_eff;
    logic             w_idle;
    logic             w_zero;

    // A programmed 0 behaves as 1 so the reload value never underflows.
    assign w_shadow_eff = (r_shadow == '0) ? ONE : r_shadow;
    assign w_idle       = !i_run && !i_freeze;
    assign w_zero       = (r_cnt == '0);

    assign o_tick    = i_run && w_zero;
    assign o_pending = r_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div    <= RST_DIV_W;
            r_cnt    <= RST_DIV_W - ONE;
            r_shadow <= '0;
            r_pend   <= 1'b0;
        end else begin
            if (i_load) begin
                r_shadow <= i_load_div;
                r_pend   <= 1'b1;
            end
            if (w_idle && r_pend) begin
                r_div  <= w_shadow_eff;
                r_cnt  <= w_shadow_eff - ONE;
                r_pend <= 1'b0;
            end else if (i_hold_reload) begin
                r_cnt <= r_div - ONE;
            end else if (i_run) begin
                if (w_zero) begin
                    // Period boundary: a pending period takes effect here, never mid-period.
                    if (r_pend) begin
                        r_div  <= w_shadow_eff;
                        r_cnt  <= w_shadow_eff - ONE;
                        r_pend <= 1'b0;
                    end else begin
                        r_cnt <= r_div - ONE;
                    end
                end else begin
                    r_cnt <= r_cnt - ONE;
                end
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Clock-enable generator for pixel, scan and physics domains with IDLE/RUN/PAUSE sequencing; optional physics tick statistics under TICK_SCHEDULER_STATS_EN.
// Latency: start at edge N gives RUN at N+1 and first tick of a period-D channel at N+D; ticks come only from registered state.
// Backpressure: o_cfg_ready drops after an accepted update and returns once every pending period has been applied.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int PHYS_DIV = DEF_PHYS_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_stop,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [1:0]       i_cfg_sel,
    input  logic [CNT_W-1:0] i_cfg_div,
    output logic             o_pix_tick,
    output logic             o_scan_tick,
    output logic             o_phys_tick,
    output logic [1:0]       o_state,
    output logic [15:0]      o_phys_count
);

    state_e r_state;
    state_e w_state_nxt;

    logic [2:0] w_pend;
    logic       w_xfer;
    logic       w_disp_run;
    logic       w_phys_run;
    logic       w_phys_freeze;
    logic       w_hold_reload;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (i_stop)       w_state_nxt = ST_IDLE;
                else if (i_pause) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (i_stop)                   w_state_nxt = ST_IDLE;
                else if (i_start && !i_pause) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_state = r_state;

    // Display channels keep running through PAUSE; only physics freezes.
    assign w_disp_run    = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign w_phys_run    = (r_state == ST_RUN);
    assign w_phys_freeze = (r_state == ST_PAUSE);
    assign w_hold_reload = (w_state_nxt == ST_IDLE);

    assign o_cfg_ready = ~|w_pend;
    assign w_xfer      = i_cfg_valid && o_cfg_ready;

    tick_channel #(.CNT_W(CNT_W), .RST_DIV(PIX_DIV)) u_pix (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_run         (w_disp_run),
        .i_freeze      (1'b0),
        .i_hold_reload (w_hold_reload),
        .i_load        (w_xfer && (i_cfg_sel == CH_PIX)),
        .i_load_div    (i_cfg_div),
        .o_tick        (o_pix_tick),
        .o_pending     (w_pend[0])
    );

    tick_channel #(.CNT_W(CNT_W), .RST_DIV(SCAN_DIV)) u_scan (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_run         (w_disp_run),
        .i_freeze      (1'b0),
        .i_hold_reload (w_hold_reload),
        .i_load        (w_xfer && (i_cfg_sel == CH_SCAN)),
        .i_load_div    (i_cfg_div),
        .o_tick        (o_scan_tick),
        .o_pending     (w_pend[1])
    );

    tick_channel #(.CNT_W(CNT_W), .RST_DIV(PHYS_DIV)) u_phys (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_run         (w_phys_run),
        .i_freeze      (w_phys_freeze),
        .i_hold_reload (w_hold_reload),
        .i_load        (w_xfer && (i_cfg_sel == CH_PHYS)),
        .i_load_div    (i_cfg_div),
        .o_tick        (o_phys_tick),
        .o_pending     (w_pend[2])
    );

`ifdef TICK_SCHEDULER_STATS_EN
    logic [15:0] r_phys_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phys_count <= '0;
        end else if (o_phys_tick) begin
            r_phys_count <= r_phys_count + 16'd1;
        end
    end

    assign o_phys_count = r_phys_count;
`else
    assign o_phys_count = '0;
`endif

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Generates the single-cycle clock-enable strobes for the pixel, 7-segment scan and game-physics domains from the one system clock, replacing free-running counter-bit clocks. The block sequences the game timebase with IDLE/RUN/PAUSE control, so physics can freeze while the display keeps refreshing. It also accepts runtime reprogramming of each channel's period through a valid/ready handshake. It sits between the top level and the VGA, scan and bird/pipe logic, all of which run on `clk` and qualify their updates with these ticks.

## Interface
- `CNT_W`, 20, width of every period counter and of `cfg_div`
- `PIX_DIV`, 4, reset period of `pix_tick`, in cycles
- `SCAN_DIV`, 65536, reset period of `scan_tick`
- `PHYS_DIV`, 524288, reset period of `phys_tick`
- `clk`  in  1  system clock; sole clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  level; IDLE→RUN, or PAUSE→RUN
- `pause`  in  1  level; RUN→PAUSE
- `stop`  in  1  level; any state→IDLE
- `cfg_valid`  in  1  period-update request
- `cfg_ready`  out  1  update can be accepted
- `cfg_sel`  in  2  channel: 0 pix, 1 scan, 2 phys, 3 reserved (accepted, discarded)
- `cfg_div`  in  CNT_W  new period; 0 is treated as 1
- `pix_tick`, `scan_tick`, `phys_tick`  out  1 each  one-cycle enables
- `state`  out  2  current state (IDLE=0, RUN=1, PAUSE=2)
- `phys_count`  out  16  physics tick counter (see Configuration)

## Operation
- Input priority, evaluated each cycle: `stop` > `pause` > `start`.
- IDLE:
  - All counters are held at their reload value.
  - All ticks are 0.
  - Leaves on `start` & !`stop`.
- RUN:
  - All three channels count down.
  - A channel's tick is high in the cycle its counter is 0; the counter then reloads `div-1`.
  - Goes to PAUSE on `pause`, to IDLE on `stop`.
- PAUSE:
  - pix and scan keep running.
  - The phys counter freezes at its current value and `phys_tick` is 0.
  - Goes to RUN on `start` & !`pause`: phys resumes from the frozen value with no extra or lost tick.
  - Goes to IDLE on `stop`.
- Config handshake:
  - Transfer occurs when `cfg_valid` & `cfg_ready` are both high.
  - The value goes to the selected channel's shadow register and that channel's pending flag is set.
  - `cfg_ready` = no pending flag set on any channel.
- Applying an update:
  - In RUN or PAUSE, pending shadows apply at that channel's next reload, so the current period always completes.
  - In IDLE, a pending shadow applies the next cycle.
  - Applying an update clears the pending flag.
- Divide rule: period = max(`cfg_div`,1) cycles. Period 1 gives a tick every cycle while counting.
- Counters are unsigned CNT_W bits and are never allowed to wrap below 0.

## Timing
- Reset values:
  - `state`=IDLE; all ticks 0; `cfg_ready`=1; `phys_count`=0.
  - Divides = parameter values; counters = div-1; no pending flags.
- `start` sampled at edge N gives `state`=RUN from cycle N+1. First tick of a channel with period D appears in cycle N+D, then every D cycles.
- `stop` sampled at edge N: ticks are 0 from cycle N+1, and counters are reloaded at N+1.
- `stop` during a pending update: the update still applies (in IDLE, next cycle).
- `cfg_ready` falls the cycle after an accepted transfer and rises the cycle after the last pending apply.
- Ticks are driven from registered state; no combinational path from inputs to ticks.
- `rst` overrides everything, including a handshake in the same cycle. The transfer is lost.

## Configuration
- `TICK_SCHEDULER_STATS_EN` defined:
  - `phys_count` increments on every `phys_tick` and wraps from 0xFFFF to 0.
  - Cleared by `rst` only.
- Undefined: `phys_count` is tied to 0 and no counter logic is built.

## Structure
- Package `tick_scheduler_pkg`:
  - state enum (IDLE, RUN, PAUSE)
  - channel select constants `CH_PIX`=0, `CH_SCAN`=1, `CH_PHYS`=2
  - default divide constants
- Sub-module `tick_channel`, instantiated three times:
  - contents: down-counter, shadow register, pending flag, reload logic
  - inputs: `run`, `freeze`, `hold_reload`, load strobe and data
  - outputs: `tick`, `pending`

## Test plan
Directed scenarios, with the bench parameters set to PIX_DIV=4, SCAN_DIV=8, PHYS_DIV=16:
- **Reset then start:** `rst`, then `start` at edge 0 → `pix_tick` at cycles 4,8,12; `scan_tick` at 8,16; `phys_tick` at 16,32; nothing before.
- **Pause/resume:** pause at cycle 10, hold 20 cycles, then start → pix/scan cadence is unchanged; next `phys_tick` comes 6 cycles after resume; `phys_count` (with the macro) shows no skipped or duplicate count.
- **Retune pix in RUN:** cfg sel=0, div=2 mid-period → current 4-cycle period finishes, then ticks every 2 cycles; `cfg_ready` is low exactly from the transfer to the apply.
- **Zero divide:** cfg sel=1, div=0 → `scan_tick` high every cycle while RUN.
- **Priority:** `stop`, `pause` and `start` all high in RUN → IDLE next cycle, all ticks 0, counters reloaded; then `start` alone → first `pix_tick` 4 cycles later.
- **Reset over handshake:** `rst` coincident with `cfg_valid` → divides return to parameter defaults and `cfg_ready`=1.
